instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch stage of the 5-stage pipeline. Supplies the instruction word that the control unit consumes.
//  Holds the fetch PC and issues word reads to instruction memory over a req/ready, rvalid port.
//  Buffers returned words in a show-ahead prefetch FIFO and presents them with a valid/ready handshake.
//  Handles branch redirects by flushing the buffer and discarding in-flight stale responses.
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset (word aligned)
//  FIFO_DEPTH  4              prefetch entries; also max outstanding memory reads (power of 2, >=2)
// PORTS
//  clock             in   1                  single clock, all state on posedge
//  reset             in   1                  synchronous, active-high
//  out_Mem_req       out  1                  read request to instruction memory
//  out_Mem_addr      out  `WordWidth         byte address of request, always [1:0]=0
//  in_Mem_ready      in   1                  memory accepts request this cycle (req&&ready = issue)
//  in_Mem_rvalid     in   1                  read data valid; responses return in issue order, latency>=1
//  in_Mem_rdata      in   `InstructionWidth  read data
//  in_Redirect       in   1                  branch taken / PC write: restart fetch at in_Redirect_pc
//  in_Redirect_pc    in   `WordWidth         new PC; bits [1:0] ignored (forced 0)
//  out_Instruction   out  `InstructionWidth  instruction at FIFO head
//  out_Instr_pc      out  `WordWidth         address the head instruction was fetched from
//  out_Instr_valid   out  1                  FIFO non-empty (and not in redirect cycle)
//  in_Instr_ready    in   1                  decode accepts head; valid&&ready pops one entry
// BEHAVIOUR
//  Reset: state=FETCH, fetch_pc=RESET_PC, FIFO empty, outstanding=0, stale=0.
//   Outputs after reset: out_Mem_req=0 in reset cycle, out_Instr_valid=0, out_Instruction=0,
//   out_Instr_pc=0, out_Mem_addr=RESET_PC. Reset mid-operation discards everything; later rvalids ignored.
//  Credit: out_Mem_req = (state==FETCH) && !in_Redirect && (occupancy + outstanding < FIFO_DEPTH).
//   out_Mem_addr = fetch_pc (combinational from register). On issue: fetch_pc += 4, outstanding++.
//   fetch_pc wraps 32'hFFFF_FFFC -> 0.
//  Response: on rvalid (state FETCH) push {rdata, pc_of_response} into FIFO, outstanding--. PC of response
//   is tracked by a resp_pc register advancing by 4 per accepted rvalid. Credit rule guarantees no overflow.
//  Latency: issue in cycle T, rvalid in T+k -> out_Instr_valid in T+k+1 (registered FIFO).
//  Pop: valid && ready removes head; simultaneous push and pop allowed at any occupancy, count unchanged.
//  FSM states:
//   FETCH: normal operation as above.
//   DRAIN: stale responses pending; out_Mem_req=0; each rvalid discarded and stale--, outstanding--;
//          stale reaching 0 -> FETCH in the next cycle.
//  Redirect (priority over all else, any state): FIFO flushed, pop ignored, out_Instr_valid=0 that cycle,
//   no issue that cycle. fetch_pc = resp_pc = {in_Redirect_pc[31:2],2'b00}.
//   stale = outstanding - (rvalid this cycle ? 1 : 0); next state = (stale==0) ? FETCH : DRAIN.
//   Redirect during DRAIN restarts with the remaining stale count, which it does not add to.
//  rvalid with outstanding==0 is a memory protocol error: ignored, no state change.
// TESTING
//  1 Reset, ready=1, 1-cycle mem latency, in_Instr_ready=1 -> addrs 0,4,8,...; instr valid from cycle 3,
//    out_Instr_pc tracks 0,4,8 with no bubbles after the pipe fills.
//  2 in_Instr_ready=0, mem latency 1 -> exactly FIFO_DEPTH(4) issues, FIFO holds 4, out_Mem_req stays 0;
//    one pop -> exactly one new issue.
//  3 Mem latency 3, 3 reads in flight, in_Redirect with pc=0x103 -> valid drops that cycle, DRAIN
//    discards 3 rvalids, next issue addr 0x100 and first delivered instr pc=0x100.
//  4 Redirect in the same cycle as an rvalid and a pop -> that rvalid is not counted as stale, FIFO ends empty,
//    stale = outstanding-1.
//  5 RESET_PC=32'hFFFF_FFF8 -> issues FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
//  6 Assert reset with 2 in flight and FIFO full -> all outputs at reset values next cycle;
//    late rvalids ignored; fetch resumes at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the fetch PC, issues word reads to instruction memory under a
// credit limit, buffers returned words with their PCs in a show-ahead FIFO and hands
// them to decode. A redirect flushes the FIFO and drains responses still in flight
// for the old path before fetching resumes.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        out_Mem_req,
    output logic [31:0] out_Mem_addr,
    input  logic        in_Mem_ready,
    input  logic        in_Mem_rvalid,
    input  logic [31:0] in_Mem_rdata,
    input  logic        in_Redirect,
    input  logic [31:0] in_Redirect_pc,
    output logic [31:0] out_Instruction,
    output logic [31:0] out_Instr_pc,
    output logic        out_Instr_valid,
    input  logic        in_Instr_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int EXT_W = CNT_W + 1;
    localparam logic [EXT_W-1:0] DEPTH_EXT = EXT_W'(FIFO_DEPTH);

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      fetch_pc_q;
    logic [31:0]      resp_pc_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] outstanding_q;
    logic [CNT_W-1:0] stale_q, stale_d;
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [31:0]      fifo_instr [FIFO_DEPTH];
    logic [31:0]      fifo_pc    [FIFO_DEPTH];

    logic        fifo_nonempty;
    logic        resp_acc;
    logic        credit_ok;
    logic        issue;
    logic        push;
    logic        pop;
    logic [31:0] redirect_pc;

    assign redirect_pc   = {in_Redirect_pc[31:2], 2'b00};
    assign fifo_nonempty = (count_q != '0);
    // A response with nothing outstanding is a protocol error and is dropped.
    assign resp_acc      = in_Mem_rvalid && (outstanding_q != '0);
    // Buffered plus in-flight words never exceed the FIFO, so a push always has room.
    assign credit_ok     = ({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_EXT;
    assign issue         = out_Mem_req && in_Mem_ready;
    // Responses landing in a redirect cycle or while draining belong to the old path.
    assign push          = resp_acc && (state_q == FETCH) && !in_Redirect;
    assign pop           = out_Instr_valid && in_Instr_ready;

    assign out_Mem_addr    = fetch_pc_q;
    assign out_Instr_valid = fifo_nonempty && !in_Redirect;
    assign out_Instruction = fifo_nonempty ? fifo_instr[rd_ptr_q] : '0;
    assign out_Instr_pc    = fifo_nonempty ? fifo_pc[rd_ptr_q]    : '0;

    // Next-state, stale-count and request logic; redirect overrides everything.
    always_comb begin
        state_d     = state_q;
        stale_d     = stale_q;
        out_Mem_req = 1'b0;
        if (in_Redirect) begin
            // The response arriving alongside the redirect is already accounted for.
            stale_d = outstanding_q - CNT_W'(resp_acc);
            state_d = (stale_d == '0) ? FETCH : DRAIN;
        end else begin
            case (state_q)
                FETCH: out_Mem_req = !reset && credit_ok;
                DRAIN: begin
                    if (resp_acc) begin
                        stale_d = stale_q - CNT_W'(1);
                        if (stale_d == '0) begin
                            state_d = FETCH;
                        end
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // Control state: FSM, PCs, credit counters and FIFO pointers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= FETCH;
            stale_q       <= '0;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            stale_q       <= stale_d;
            outstanding_q <= outstanding_q + CNT_W'(issue) - CNT_W'(resp_acc);
            if (in_Redirect) begin
                fetch_pc_q <= redirect_pc;
                resp_pc_q  <= redirect_pc;
                count_q    <= '0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
            end else begin
                if (issue) begin
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                end
                if (push) begin
                    resp_pc_q <= resp_pc_q + 32'd4;
                    wr_ptr_q  <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // FIFO storage; contents are only meaningful below count_q, so no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_instr[wr_ptr_q] <= in_Mem_rdata;
            fifo_pc[wr_ptr_q]    <= resp_pc_q;
        end
    end

endmodule
